gain_ramp_ctrl: RTL and testbench

- Sequences the gain value applied by the RFNoC gain datapath.
- Accepts a target gain from the register/control side and moves the live gain toward it in fixed steps, one step per programmed number of accepted samples.
- Changes occur only on sample-transfer boundaries of the datapath input stream, so no sample sees a mid-transfer gain change.
- Sits between the gain register block and the multiplier/clip datapath inside the gain block.

---
 rtl/gain_ramp_pkg.sv | 28 ++
 rtl/gain_ramp_if.sv | 21 ++
 rtl/gain_ramp_beat_cnt.sv | 46 ++++
 rtl/gain_ramp_ctrl.sv | 112 +++++++++++
 tb/tb_gain_ramp_ctrl.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gain_ramp_pkg.sv
// Shared types and the step arithmetic for the gain ramp sequencer.
// Step math is done in 32-bit int so target-current never overflows for GAIN_W < 32.
package gain_ramp_pkg;

    localparam int GAIN_W_DEF = 16;

    typedef logic signed [GAIN_W_DEF-1:0] gain_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        JUMP = 2'd2
    } ramp_state_e;

    // Next gain after one step toward target; lands exactly on target when within one step.
    function automatic int sat_step(input int current, input int target, input int step);
        int diff;
        diff = target - current;
        if ((diff <= step) && (diff >= -step)) begin
            return target;
        end else if (diff > 0) begin
            return current + step;
        end else begin
            return current - step;
        end
    endfunction

endpackage

// File: rtl/gain_ramp_if.sv
// Target handshake plus the observed datapath input stream of the gain block.
interface gain_ramp_if #(
    parameter int GAIN_W = 16
);
    logic signed [GAIN_W-1:0] s_target_tdata;
    logic                     s_target_tvalid;
    logic                     s_target_tready;
    logic                     mon_tvalid;
    logic                     mon_tready;
    logic                     mon_tlast;

    modport master (
        output s_target_tdata, s_target_tvalid, mon_tvalid, mon_tready, mon_tlast,
        input  s_target_tready
    );

    modport slave (
        input  s_target_tdata, s_target_tvalid, mon_tvalid, mon_tready, mon_tlast,
        output s_target_tready
    );
endinterface

// File: rtl/gain_ramp_beat_cnt.sv
// Interval counter: step_tick fires on the qualifying beat that completes max(interval,1) beats.
// With GAIN_RAMP_PKT_ALIGN_EN defined only tlast beats qualify, so the count is in packets.
module gain_ramp_beat_cnt #(
    parameter int INTERVAL_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  beat,
    input  logic                  tlast,
    input  logic                  en,
    input  logic                  clr,
    input  logic [INTERVAL_W-1:0] interval,
    output logic                  qual_beat,
    output logic                  step_tick
);
    logic [INTERVAL_W-1:0] cnt_q, cnt_d;
    logic [INTERVAL_W-1:0] last_cnt;

`ifdef GAIN_RAMP_PKT_ALIGN_EN
    assign qual_beat = beat && tlast;
`else
    logic unused_tlast;
    assign unused_tlast = tlast;
    assign qual_beat    = beat;
`endif

    assign last_cnt  = (interval == '0) ? '0 : interval - INTERVAL_W'(1);
    assign step_tick = en && qual_beat && (cnt_q == last_cnt);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && qual_beat) begin
            cnt_d = (cnt_q == last_cnt) ? '0 : cnt_q + INTERVAL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/gain_ramp_ctrl.sv
// Gain ramp sequencer: moves gain_out toward the accepted target on datapath sample beats.
// Optional packet alignment of updates via GAIN_RAMP_PKT_ALIGN_EN (see gain_ramp_beat_cnt).
//   state | meaning
//   IDLE  | gain_out == target, waiting for a new target
//   RAMP  | stepping gain_out toward target every interval beats
//   JUMP  | step is 0, load target on the next beat (or at once if no traffic yet)
module gain_ramp_ctrl
    import gain_ramp_pkg::*;
#(
    parameter int GAIN_W     = 16,
    parameter int INIT_GAIN  = 1,
    parameter int INTERVAL_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    gain_ramp_if.slave               bus,
    input  logic [GAIN_W-2:0]        cfg_step,
    input  logic [INTERVAL_W-1:0]    cfg_interval,
    output logic signed [GAIN_W-1:0] gain_out,
    output logic                     ramp_active,
    output logic                     ramp_done
);
    ramp_state_e              state_q, state_d;
    logic signed [GAIN_W-1:0] gain_q, gain_d;
    logic signed [GAIN_W-1:0] target_q, target_d;
    logic signed [GAIN_W-1:0] eff_target;
    logic                     done_q, done_d;
    logic                     seen_q, seen_d;
    logic                     beat, qual_beat, step_tick;
    logic                     cnt_clr, jump_fire, tgt_acc;

    assign beat = bus.mon_tvalid && bus.mon_tready;

    gain_ramp_beat_cnt #(
        .INTERVAL_W (INTERVAL_W)
    ) u_beat_cnt (
        .clk       (clk),
        .rst       (rst),
        .beat      (beat),
        .tlast     (bus.mon_tlast),
        .en        (state_q == RAMP),
        .clr       (cnt_clr),
        .interval  (cfg_interval),
        .qual_beat (qual_beat),
        .step_tick (step_tick)
    );

    // Before any traffic there is no sample to align to, so a jump applies immediately.
    assign jump_fire           = (state_q == JUMP) && (qual_beat || !seen_q);
    assign bus.s_target_tready = !jump_fire;
    assign tgt_acc             = bus.s_target_tvalid && !jump_fire;
    assign eff_target          = tgt_acc ? bus.s_target_tdata : target_q;

    always_comb begin
        state_d  = state_q;
        gain_d   = gain_q;
        target_d = eff_target;
        done_d   = 1'b0;
        cnt_clr  = 1'b0;
        seen_d   = seen_q || beat;
        unique case (state_q)
            IDLE: begin
                if (tgt_acc && (bus.s_target_tdata != gain_q)) begin
                    if (cfg_step == '0) begin
                        state_d = JUMP;
                    end else begin
                        state_d = RAMP;
                        cnt_clr = 1'b1;
                    end
                end
            end
            JUMP: begin
                if (jump_fire) begin
                    gain_d  = target_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            RAMP: begin
                if (step_tick) begin
                    gain_d = GAIN_W'(sat_step(int'(gain_q), int'(eff_target),
                                              int'({1'b0, cfg_step})));
                    if (gain_d == eff_target) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gain_q   <= GAIN_W'(INIT_GAIN);
            target_q <= GAIN_W'(INIT_GAIN);
            done_q   <= 1'b0;
            seen_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gain_q   <= gain_d;
            target_q <= target_d;
            done_q   <= done_d;
            seen_q   <= seen_d;
        end
    end

    assign gain_out    = gain_q;
    assign ramp_active = (state_q != IDLE);
    assign ramp_done   = done_q;
endmodule

// File: tb/tb_gain_ramp_ctrl.sv
// Self-checking bench for gain_ramp_ctrl: directed scenarios plus random traffic against a reference model.
// Packet-aligned scenario is compiled when GAIN_RAMP_PKT_ALIGN_EN is defined.
module tb_gain_ramp_ctrl;

    logic               clk;
    logic               rst;
    logic [14:0]        cfg_step;
    logic [15:0]        cfg_interval;
    logic signed [15:0] gain_out;
    logic               ramp_active;
    logic               ramp_done;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int m_gain, m_target, m_count;
    bit m_ramping, m_jumping, m_seen, m_done;

    gain_ramp_if #(.GAIN_W(16)) bus ();

    gain_ramp_ctrl #(
        .GAIN_W     (16),
        .INIT_GAIN  (1),
        .INTERVAL_W (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .cfg_step     (cfg_step),
        .cfg_interval (cfg_interval),
        .gain_out     (gain_out),
        .ramp_active  (ramp_active),
        .ramp_done    (ramp_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs after a falling edge, predict the next edge, compare after it.
    task automatic cycle(input bit tv, input int td, input bit mv, input bit mr, input bit ml);
        bit beat, qual, acc, jump_now;
        int new_tgt, diff, n;
        bus.s_target_tvalid = tv;
        bus.s_target_tdata  = 16'(td);
        bus.mon_tvalid      = mv;
        bus.mon_tready      = mr;
        bus.mon_tlast       = ml;
        #1;
        beat = mv && mr;
        qual = beat;
`ifdef GAIN_RAMP_PKT_ALIGN_EN
        qual = beat && ml;
`endif
        jump_now = m_jumping && (qual || !m_seen);
        check_val("tready", int'(bus.s_target_tready), int'(!jump_now));
        acc     = tv && !jump_now;
        new_tgt = acc ? td : m_target;
        m_done  = 1'b0;
        if (m_jumping) begin
            if (jump_now) begin
                m_gain    = m_target;
                m_done    = 1'b1;
                m_jumping = 1'b0;
            end
        end else if (m_ramping) begin
            if (qual) begin
                n = (cfg_interval == 0) ? 1 : int'(cfg_interval);
                m_count++;
                if (m_count >= n) begin
                    m_count = 0;
                    diff = new_tgt - m_gain;
                    if (diff < 0) diff = -diff;
                    if (diff <= int'(cfg_step)) begin
                        m_gain    = new_tgt;
                        m_done    = 1'b1;
                        m_ramping = 1'b0;
                    end else if (new_tgt > m_gain) begin
                        m_gain = m_gain + int'(cfg_step);
                    end else begin
                        m_gain = m_gain - int'(cfg_step);
                    end
                end
            end
        end else if (acc && (td != m_gain)) begin
            if (cfg_step == 0) m_jumping = 1'b1;
            else begin
                m_ramping = 1'b1;
                m_count   = 0;
            end
        end
        m_target = new_tgt;
        m_seen   = m_seen || beat;
        @(negedge clk);
        check_val("gain", int'(gain_out), m_gain);
        check_val("done", int'(ramp_done), int'(m_done));
        check_val("active", int'(ramp_active), int'(m_ramping || m_jumping));
    endtask

    task automatic do_reset();
        rst                 = 1'b1;
        bus.s_target_tvalid = 1'b0;
        bus.s_target_tdata  = '0;
        bus.mon_tvalid      = 1'b0;
        bus.mon_tready      = 1'b0;
        bus.mon_tlast       = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        m_gain    = 1;
        m_target  = 1;
        m_count   = 0;
        m_ramping = 1'b0;
        m_jumping = 1'b0;
        m_seen    = 1'b0;
        m_done    = 1'b0;
        check_val("rst_gain", int'(gain_out), 1);
        check_val("rst_active", int'(ramp_active), 0);
        check_val("rst_done", int'(ramp_done), 0);
        check_val("rst_tready", int'(bus.s_target_tready), 1);
    endtask

    task automatic jump_to(input int v);
        cfg_step = '0;
        cycle(1'b1, v, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b1, 1'b1);
        check_val("jump_to", int'(gain_out), v);
    endtask

    initial begin
        int exp5[5];
        int k;
        cfg_step     = '0;
        cfg_interval = 16'd1;
        do_reset();

        // traffic with no target: gain holds at reset value
        for (int i = 0; i < 10; i++) cycle(1'b0, 0, 1'b1, 1'b1, 1'b1);
        check_val("idle_gain", int'(gain_out), 1);

        // jump to 37 on the next beat
        cfg_step = '0;
        cycle(1'b1, 37, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
        check_val("jump_wait", int'(gain_out), 1);
        cycle(1'b0, 0, 1'b1, 1'b1, 1'b1);
        check_val("jump_gain", int'(gain_out), 37);
        check_val("jump_done", int'(ramp_done), 1);
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
        check_val("jump_done_off", int'(ramp_done), 0);

        // 0 -> 25, step 10, every 4 beats
        jump_to(0);
        cfg_step     = 15'd10;
        cfg_interval = 16'd4;
        cycle(1'b1, 25, 1'b0, 1'b0, 1'b0);
        for (int b = 1; b <= 12; b++) begin
            cycle(1'b0, 0, 1'b1, 1'b1, 1'b1);
            if (b == 4)  check_val("r25_b4", int'(gain_out), 10);
            if (b == 8)  check_val("r25_b8", int'(gain_out), 20);
            if (b == 12) check_val("r25_b12", int'(gain_out), 25);
        end
        check_val("r25_done", int'(ramp_done), 1);

        // 100 -> -255 in steps of 50
        jump_to(100);
        cfg_step     = 15'd50;
        cfg_interval = 16'd1;
        cycle(1'b1, -255, 1'b0, 1'b0, 1'b0);
        for (int s = 1; s <= 8; s++) begin
            cycle(1'b0, 0, 1'b1, 1'b1, 1'b1);
            check_val("neg_ramp", int'(gain_out), (s <= 7) ? 100 - 50 * s : -255);
        end
        check_val("neg_done", int'(ramp_done), 1);

        // full-scale swing, must not wrap
        jump_to(32767);
        cfg_step = 15'd32767;
        cycle(1'b1, -32768, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b1, 1'b1);
        check_val("fs_first", int'(gain_out), 0);
        k = 0;
        while (ramp_active && k < 4) begin
            cycle(1'b0, 0, 1'b1, 1'b1, 1'b1);
            k++;
        end
        check_val("fs_end_active", int'(ramp_active), 0);
        check_val("fs_end_gain", int'(gain_out), -32768);

        // retarget to -20 while at 30, accepted together with a step beat
        jump_to(0);
        cfg_step     = 15'd10;
        cfg_interval = 16'd1;
        cycle(1'b1, 100, 1'b0, 1'b0, 1'b0);
        for (int s = 0; s < 3; s++) cycle(1'b0, 0, 1'b1, 1'b1, 1'b1);
        check_val("rt_at30", int'(gain_out), 30);
        exp5 = '{20, 10, 0, -10, -20};
        for (int s = 0; s < 5; s++) begin
            if (s == 0) cycle(1'b1, -20, 1'b1, 1'b1, 1'b1);
            else        cycle(1'b0, 0, 1'b1, 1'b1, 1'b1);
            check_val("rt_gain", int'(gain_out), exp5[s]);
            check_val("rt_done", int'(ramp_done), (s == 4) ? 1 : 0);
        end

        // retarget to the current gain ends the ramp at the next step decision
        jump_to(0);
        cfg_step     = 15'd10;
        cfg_interval = 16'd2;
        cycle(1'b1, 100, 1'b0, 1'b0, 1'b0);
        for (int s = 0; s < 4; s++) cycle(1'b0, 0, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 20, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b1, 1'b1);
        check_val("eq_hold", int'(ramp_active), 1);
        cycle(1'b0, 0, 1'b1, 1'b1, 1'b1);
        check_val("eq_gain", int'(gain_out), 20);
        check_val("eq_done", int'(ramp_done), 1);
        check_val("eq_active", int'(ramp_active), 0);

        // stalled stream: gain holds, ramp stays active
        jump_to(0);
        cfg_step     = 15'd10;
        cfg_interval = 16'd1;
        cycle(1'b1, 50, 1'b0, 1'b0, 1'b0);
        for (int s = 0; s < 20; s++) cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
        check_val("stall_gain", int'(gain_out), 0);
        check_val("stall_active", int'(ramp_active), 1);

        // reset in the middle of the ramp, then a jump with no traffic since reset
        do_reset();
        cfg_step = '0;
        cycle(1'b1, 5, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
        check_val("notraffic_jump", int'(gain_out), 5);

`ifdef GAIN_RAMP_PKT_ALIGN_EN
        begin
            int idx;
            bit mv, mr;
            int exp_g;
            jump_to(0);
            cfg_step     = 15'd5;
            cfg_interval = 16'd1;
            cycle(1'b1, 15, 1'b0, 1'b0, 1'b0);
            idx = 0;
            for (int c = 0; c < 2000 && idx < 192; c++) begin
                mv = ($urandom_range(0, 3) != 0);
                mr = ($urandom_range(0, 3) != 0);
                cycle(1'b0, 0, mv, mr, (idx % 64) == 63);
                if (mv && mr) idx++;
                exp_g = 5 * (idx / 64);
                if (exp_g > 15) exp_g = 15;
                check_val("pkt_gain", int'(gain_out), exp_g);
            end
            check_val("pkt_samples", idx, 192);
        end
`endif

        // random traffic and targets against the model
        cfg_step     = 15'd37;
        cfg_interval = 16'd2;
        for (int i = 0; i < 1500; i++) begin
            int td;
            if (!m_ramping && !m_jumping && $urandom_range(0, 9) == 0) begin
                cfg_step     = 15'(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 600));
                cfg_interval = 16'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 7) == 0) td = int'($urandom_range(0, 65535)) - 32768;
            else                           td = int'($urandom_range(0, 4000)) - 2000;
            cycle($urandom_range(0, 3) == 0, td,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
